// File: rtl/bpred_types.sv
// Branch-predictor types: two-bit saturating counter encoding and its update rule.
package bpred_types;

   typedef logic [1:0] pht_ctr_t;

   localparam pht_ctr_t CTR_SNT = 2'b00;
   localparam pht_ctr_t CTR_WNT = 2'b01;
   localparam pht_ctr_t CTR_WT  = 2'b10;
   localparam pht_ctr_t CTR_ST  = 2'b11;

   // Saturating step: the two strong states absorb further moves in their direction.
   function automatic pht_ctr_t ctr_update(input pht_ctr_t ctr, input logic taken);
      pht_ctr_t result;
      if (taken) begin
         result = (ctr == CTR_ST) ? CTR_ST : pht_ctr_t'(ctr + 2'd1);
      end else begin
         result = (ctr == CTR_SNT) ? CTR_SNT : pht_ctr_t'(ctr - 2'd1);
      end
      return result;
   endfunction

endpackage

// File: rtl/rv32i_types.sv
// RV32I base-ISA opcode encodings shared across the pipeline.
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

endpackage

// File: rtl/pc_register.sv
// Program-counter register with a load enable and a parametrised reset address.
module pc_register #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] pc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= RESET_PC;
      end else if (load) begin
         pc_reg <= in;
      end
   end

   assign out = pc_reg;

endmodule

// File: rtl/pht_2bit.sv
// Pattern history table of two-bit counters: combinational lookup, synchronous
// saturating update. A same-cycle lookup of the updated entry sees the old value.
module pht_2bit
   import bpred_types::*;
#(
   parameter int       PHT_IDX_BITS = 6,
   parameter pht_ctr_t CTR_INIT     = CTR_WNT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PHT_IDX_BITS-1:0] rd_idx,
   output logic                    rd_taken,
   input  logic                    wr_en,
   input  logic [PHT_IDX_BITS-1:0] wr_idx,
   input  logic                    wr_taken
);

   localparam int DEPTH = 1 << PHT_IDX_BITS;

   pht_ctr_t table_reg [DEPTH];

   // Every entry must return to CTR_INIT on reset, so each one is its own register.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (reset) begin
               table_reg[gi] <= CTR_INIT;
            end else if (wr_en && (wr_idx == PHT_IDX_BITS'(gi))) begin
               table_reg[gi] <= ctr_update(table_reg[gi], wr_taken);
            end
         end
      end
   endgenerate

   assign rd_taken = table_reg[rd_idx][1];

endmodule

// File: rtl/if_stage_pht.sv
// Instruction-fetch stage: owns the PC, predicts conditional branches from a
// per-index PHT (optionally gshare-hashed), resolves jal, and accepts EX redirects.
module if_stage_pht
   import rv32i_types::*;
   import bpred_types::*;
#(
   parameter int          PHT_IDX_BITS = 6,
   parameter int          GHR_BITS     = 0,
   parameter logic [31:0] RESET_PC     = 32'h0000_0060,
   parameter pht_ctr_t    CTR_INIT     = CTR_WNT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pipeline_en,
   input  logic [31:0]             inst_rdata,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc,
   input  logic                    upd_valid,
   input  logic [PHT_IDX_BITS-1:0] upd_idx,
   input  logic                    upd_taken,
   input  logic                    upd_mispredict,
   output logic [31:0]             inst_addr,
   output logic                    inst_read,
   output logic [31:0]             IR_regs_in,
   output logic                    predicted_branch,
   output logic [PHT_IDX_BITS-1:0] pred_idx,
   output logic [31:0]             perf_branches,
   output logic [31:0]             perf_mispredicts
);

   logic                    upd_apply;
   logic [PHT_IDX_BITS-1:0] hist;
   logic [PHT_IDX_BITS-1:0] lookup_idx;
   logic                    pht_taken;
   logic [31:0]             pc_in;
   logic [31:0]             b_imm;
   logic [31:0]             j_imm;
   rv32i_opcode             opcode;
   logic [31:0]             perf_branches_reg;
   logic [31:0]             perf_mispredicts_reg;

   assign upd_apply = upd_valid && pipeline_en;

   // History is trained only by resolved outcomes, never by fetch-time guesses.
   generate
      if (GHR_BITS > 0) begin : g_ghr
         logic [GHR_BITS-1:0] ghr_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               ghr_reg <= '0;
            end else if (upd_apply) begin
               ghr_reg <= GHR_BITS'({ghr_reg, upd_taken});
            end
         end
         assign hist = PHT_IDX_BITS'(ghr_reg);
      end else begin : g_bimodal
         assign hist = '0;
      end
   endgenerate

   assign lookup_idx = inst_addr[PHT_IDX_BITS+1:2] ^ hist;
   assign pred_idx   = lookup_idx;

   pht_2bit #(
      .PHT_IDX_BITS(PHT_IDX_BITS),
      .CTR_INIT    (CTR_INIT)
   ) u_pht (
      .clk     (clk),
      .reset   (reset),
      .rd_idx  (lookup_idx),
      .rd_taken(pht_taken),
      .wr_en   (upd_apply),
      .wr_idx  (upd_idx),
      .wr_taken(upd_taken)
   );

   assign opcode = rv32i_opcode'(inst_rdata[6:0]);
   assign b_imm  = {{20{inst_rdata[31]}}, inst_rdata[7], inst_rdata[30:25],
                    inst_rdata[11:8], 1'b0};
   assign j_imm  = {{12{inst_rdata[31]}}, inst_rdata[19:12], inst_rdata[20],
                    inst_rdata[30:21], 1'b0};

   always_comb begin
      pc_in            = inst_addr + 32'd4;
      IR_regs_in       = inst_rdata;
      predicted_branch = 1'b0;
      if (redirect) begin
         pc_in      = redirect_pc;
         IR_regs_in = 32'h0;
      end else if ((opcode == op_br) && pht_taken) begin
         pc_in            = inst_addr + b_imm;
         predicted_branch = 1'b1;
      end else if (opcode == op_jal) begin
         pc_in = inst_addr + j_imm;
      end
   end

   pc_register #(
      .WIDTH   (32),
      .RESET_PC(RESET_PC)
   ) u_pc (
      .clk  (clk),
      .reset(reset),
      .load (pipeline_en),
      .in   (pc_in),
      .out  (inst_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_branches_reg    <= '0;
         perf_mispredicts_reg <= '0;
      end else if (upd_apply) begin
         perf_branches_reg <= perf_branches_reg + 32'd1;
         if (upd_mispredict) begin
            perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
         end
      end
   end

   assign inst_read        = 1'b1;
   assign perf_branches    = perf_branches_reg;
   assign perf_mispredicts = perf_mispredicts_reg;

endmodule

// File: doc/if_stage_pht.md
# if_stage_pht

Parametrised instruction-fetch stage with an indexed two-bit pattern history table (PHT) and optional global-history (gshare) hashing. It owns the PC, presents the fetch address to instruction memory, predicts conditional branches per PC instead of with one shared counter, and resolves `jal` in IF. It sits at the head of the pipeline: it feeds the IF/ID IR registers and takes redirect and predictor-update traffic from EX.

## Interface
Parameters:
- `PHT_IDX_BITS`, default 6: table has 2^PHT_IDX_BITS two-bit counters.
- `GHR_BITS`, default 0: global history length.
  - 0 selects bimodal indexing.
  - Legal range 0..PHT_IDX_BITS.
- `RESET_PC`, default 32'h0000_0060: PC after reset.
- `CTR_INIT`, default 2'b01 (weakly not-taken): counter value after reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pipeline_en`  in  1  global advance enable; 0 freezes all state.
- `inst_rdata`  in  32  instruction returned for `inst_addr`.
- `redirect`  in  1  EX demands a PC change (mispredict, or any `jalr`).
- `redirect_pc`  in  32  correct next PC when `redirect`=1.
- `upd_valid`  in  1  EX resolved a conditional branch this cycle.
- `upd_idx`  in  PHT_IDX_BITS  PHT index carried down with that branch.
- `upd_taken`  in  1  actual outcome of that branch.
- `upd_mispredict`  in  1  prediction was wrong.
- `inst_addr`  out  32  current PC / fetch address.
- `inst_read`  out  1  constant 1.
- `IR_regs_in`  out  32  next IR value.
- `predicted_branch`  out  1  IF predicted this branch taken.
- `pred_idx`  out  PHT_IDX_BITS  index used for this lookup; the pipeline carries it to EX.
- `perf_branches`  out  32  resolved conditional branches.
- `perf_mispredicts`  out  32  mispredicted conditional branches.

## Operation
- Index:
  - `idx = inst_addr[PHT_IDX_BITS+1:2]`.
  - If GHR_BITS>0, the low bits of `idx` are XORed with the GHR, zero-extended.
  - `pred_idx = idx`.
- Next-PC priority:
  - `redirect` → PC_in = `redirect_pc`; `IR_regs_in` = 32'h0 (bubble); `predicted_branch` = 0.
  - `inst_rdata` opcode `op_br` and `pht[idx][1]`=1 → PC_in = `inst_addr` + B-imm; `predicted_branch` = 1.
  - opcode `op_jal` → PC_in = `inst_addr` + J-imm.
  - Otherwise → `inst_addr` + 4.
  - In all non-redirect cases `IR_regs_in` = `inst_rdata`.
- Immediates are sign-extended to 32 bits. All adds are 32-bit, modulo 2^32: wrap past 32'hFFFF_FFFC is allowed.
- PC loads PC_in only when `pipeline_en`=1.
- PHT update:
  - Applied when `upd_valid`&&`pipeline_en`.
  - Counter at `upd_idx` saturates up on `upd_taken`, down otherwise: 00 and 11 are sticky.
  - Only conditional branches update; `jal`/`jalr` never touch the PHT or GHR.
- GHR is non-speculative: it shifts left, inserting `upd_taken` at bit 0, under the same condition as the PHT update.
- Perf counters:
  - `perf_branches` increments on each applied update.
  - `perf_mispredicts` increments when that update also has `upd_mispredict`.
  - Both wrap at 2^32.

## Timing
- Reset values:
  - `inst_addr` = RESET_PC; `inst_read` = 1.
  - All PHT entries = CTR_INIT; GHR = 0.
  - Perf counters = 0.
  - `IR_regs_in`, `predicted_branch` and `pred_idx` are combinational from `inst_rdata`/`inst_addr`, valid in the first cycle after reset.
- Reset mid-operation reinitialises every register that cycle; any `redirect` or `upd_valid` presented during the reset cycle is discarded.
- Fetch path is combinational from `inst_rdata` to PC_in; the new PC appears one cycle after `pipeline_en`.
- PHT/GHR/perf updates become visible the cycle after they are applied.
- Same-cycle lookup and update of one index: the lookup sees the pre-update value (read-before-write).
- `redirect` with `pipeline_en`=0 has no effect. EX holds `redirect`/`upd_*` stable during stalls, so each is applied exactly once.
- `redirect` and `upd_valid` in the same cycle are both applied.

## Structure
- Shared package `bpred_types`:
  - typedef `pht_ctr_t` (2-bit).
  - constants `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11.
  - `rv32i_opcode` continues to come from `rv32i_types`.
- Sub-module `pht_2bit`:
  - Parameters PHT_IDX_BITS and CTR_INIT.
  - One combinational read port, one synchronous saturating-update port, synchronous reset.
- PC uses the existing `pc_register`, extended with a RESET_PC parameter.

## Test plan
- Reset, then `inst_rdata`=NOP, `pipeline_en`=1 for 3 cycles → `inst_addr` 0x60, 0x64, 0x68; perf counters 0.
- Bimodal: branch at 0x80 with B-imm +16. Apply 1 update taken at idx 0x20 → the following fetch of 0x80 predicts taken, next `inst_addr`=0x90, `predicted_branch`=1. A branch at 0x84 (idx 0x21) still predicts not-taken.
- Saturation: 5 taken updates to one idx, then 2 not-taken → counter 11 then 01; predicts not-taken.
- Gshare (GHR_BITS=2): 2 taken updates set GHR=11 → `pred_idx` for PC 0x80 equals 0x23.
- `redirect`=1, `redirect_pc`=0x200, with `inst_rdata` a predicted-taken branch → next `inst_addr`=0x200, `IR_regs_in`=0, `predicted_branch`=0.
- Stall: `pipeline_en`=0 for 4 cycles with `upd_valid`=1, `upd_mispredict`=1 held → PC, PHT and perf unchanged. On release: exactly one increment of each perf counter.
